// File: rtl/y86_load_pkg.sv
// Shared definitions for the instruction/data memory image loaders:
// FSM state encoding, frame error codes and length-prefix size.
package y86_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } load_state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TOO_LONG = 2'd1;
    localparam logic [1:0] ERR_SHORT    = 2'd2;
    localparam logic [1:0] ERR_NO_LAST  = 2'd3;

    localparam int unsigned LEN_BYTES = 2;

    function automatic logic is_busy(input load_state_e s);
        return s inside {ST_LEN0, ST_LEN1, ST_DATA};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Stream-in handshake plus imem byte write port of the image loader.
// master = stream source / memory side, slave = loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_wr_stage.sv
// Registered memory write-port stage: one write pulse in the cycle after
// each accept strobe, address/data held between writes.
module imem_wr_stage #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              accept_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        data_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        wdata_o
);
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;

    always_comb begin
        we_d    = accept_i;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept_i) begin
            addr_d  = addr_i;
            wdata_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory from address 0
// and releases the processor (cpu_run) only after the last byte is committed.
module imem_loader
    import y86_load_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    imem_loader_if.slave    bus,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [1:0]      err_code,
    output logic [ADDR_W:0] bytes_loaded,
    output logic            cpu_run
);
    localparam int unsigned MEM_BYTES = 1 << ADDR_W;
    localparam int unsigned LEN_W     = 8 * LEN_BYTES;

    load_state_e      state_q;
    logic [LEN_W-1:0] len_q;
    logic [ADDR_W:0]  cnt_q;
    logic             done_q;
    logic             cpu_run_q;
    logic             err_q;
    logic [1:0]       err_code_q;

    logic             xfer;
    logic             wr_accept;
    logic             last_payload;
    logic [LEN_W-1:0] len_full;

    assign busy         = is_busy(state_q);
    assign bus.in_ready = busy;
    assign xfer         = bus.in_valid & busy;
    assign wr_accept    = xfer & (state_q == ST_DATA);
    assign len_full     = {bus.in_data, len_q[7:0]};
    assign last_payload = (32'(cnt_q) + 32'd1) == 32'(len_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            cpu_run_q  <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_q    <= ST_LEN0;
                        len_q      <= '0;
                        cnt_q      <= '0;
                        done_q     <= 1'b0;
                        cpu_run_q  <= 1'b0;
                        err_q      <= 1'b0;
                        err_code_q <= ERR_NONE;
                    end else if (state_q == ST_DONE) begin
                        // one cycle behind done so the final write has landed before fetch
                        cpu_run_q <= 1'b1;
                    end
                end
                ST_LEN0: begin
                    if (xfer) begin
                        len_q <= {{(LEN_W-8){1'b0}}, bus.in_data};
                        if (bus.in_last) begin
                            state_q    <= ST_ERR;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_SHORT;
                        end else begin
                            state_q <= ST_LEN1;
                        end
                    end
                end
                ST_LEN1: begin
                    if (xfer) begin
                        len_q <= len_full;
                        if (32'(len_full) > MEM_BYTES) begin
                            state_q    <= ST_ERR;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_TOO_LONG;
                        end else if (len_full == '0) begin
                            if (bus.in_last) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q    <= ST_ERR;
                                err_q      <= 1'b1;
                                err_code_q <= ERR_NO_LAST;
                            end
                        end else if (bus.in_last) begin
                            state_q    <= ST_ERR;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_SHORT;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                        if (last_payload) begin
                            if (bus.in_last) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q    <= ST_ERR;
                                err_q      <= 1'b1;
                                err_code_q <= ERR_NO_LAST;
                            end
                        end else if (bus.in_last) begin
                            state_q    <= ST_ERR;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_SHORT;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    imem_wr_stage #(.ADDR_W(ADDR_W)) u_wr_stage (
        .clk_i    (clock),
        .rst_i    (reset),
        .accept_i (wr_accept),
        .addr_i   (cnt_q[ADDR_W-1:0]),
        .data_i   (bus.in_data),
        .we_o     (bus.mem_we),
        .addr_o   (bus.mem_addr),
        .wdata_o  (bus.mem_wdata)
    );

    assign done         = done_q;
    assign cpu_run      = cpu_run_q;
    assign error        = err_q;
    assign err_code     = err_code_q;
    assign bytes_loaded = cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-level reference model (terminating byte index
// and outcome derived from the frame rules) checked every cycle.
module tb_imem_loader;
    localparam int unsigned AW  = 4;
    localparam int          MEM = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done, error, cpu_run;
    logic [1:0]    err_code;
    logic [AW:0]   bytes_loaded;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .bytes_loaded (bytes_loaded),
        .cpu_run      (cpu_run)
    );

    always #5 clock = ~clock;

    // pending frame and its derived outcome
    int  fb [64];
    bit  fl [64];
    int  flen;
    int  m_t, m_code;
    // model of the frame in flight
    int  cur_t, cur_code;
    bit  m_active;
    int  m_n, m_k;
    bit  m_we;
    int  m_waddr, m_wdata;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_en   = 1'b0;
    logic [7:0] shadow [0:MEM-1];

    function automatic bit exp_busy();
        return m_active && (m_n <= cur_t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // lastpos = frame index carrying in_last, -1 for none
    task automatic build(input int len, input int lastpos);
        flen = 2 + ((len <= MEM) ? len : 0);
        for (int i = 0; i < 64; i++) begin
            fb[i] = int'($urandom_range(0, 255));
            fl[i] = 1'b0;
        end
        fb[0] = len & 255;
        fb[1] = (len >> 8) & 255;
        if (lastpos >= 0 && lastpos < flen) fl[lastpos] = 1'b1;
        if (fl[0]) begin
            m_t = 0; m_code = 2;
        end else if (len > MEM) begin
            m_t = 1; m_code = 1;
        end else if (len == 0) begin
            m_t = 1; m_code = fl[1] ? 0 : 3;
        end else if (fl[1]) begin
            m_t = 1; m_code = 2;
        end else begin
            m_t = 1 + len; m_code = fl[1+len] ? 0 : 3;
            for (int i = 2; i < 1 + len; i++) begin
                if (fl[i]) begin
                    m_t = i; m_code = 2; break;
                end
            end
        end
    endtask

    task automatic tick(input bit v, input bit s, input bit r);
        bit b;
        b = exp_busy();
        bus.in_valid = v;
        if (b) begin
            bus.in_data = 8'(fb[m_n]);
            bus.in_last = fl[m_n];
        end else begin
            bus.in_data = 8'($urandom_range(0, 255));
            bus.in_last = 1'($urandom_range(0, 1));
        end
        start = s;
        reset = r;
        @(posedge clock);
        m_we = 1'b0;
        if (r) begin
            m_active = 1'b0; m_n = 0; m_k = 0;
        end else if (s && !b) begin
            m_active = 1'b1; m_n = 0; m_k = 0;
            cur_t = m_t; cur_code = m_code;
        end else if (v && b) begin
            if (m_n >= 2) begin
                m_we = 1'b1; m_waddr = m_n - 2; m_wdata = fb[m_n];
            end
            m_n++;
            m_k = 0;
        end else if (m_k < 3) begin
            m_k++;
        end
        #1;
    endtask

    task automatic run_frame(input int mode);
        int guard;
        bit v;
        guard = 0;
        while (exp_busy() && guard < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            tick(v, 1'b0, 1'b0);
            guard++;
        end
        if (exp_busy()) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: still busy after %0d cycles, required idle", guard);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_nominal_payload();
        fb[2] = 8'h30; fb[3] = 8'hF2; fb[4] = 8'h0A; fb[5] = 8'h00;
    endtask

    always @(negedge clock) begin : compare
        bit term, ok;
        if (chk_en) begin
            term = m_active && (m_n > cur_t);
            ok   = term && (cur_code == 0);
            chk("in_ready", bus.in_ready, exp_busy());
            chk("busy", busy, exp_busy());
            chk("done", done, ok);
            chk("cpu_run", cpu_run, ok && (m_k >= 1));
            chk("error", error, term && (cur_code != 0));
            chk("err_code", err_code, term ? cur_code : 0);
            chk("bytes_loaded", bytes_loaded, (m_n > 2) ? m_n - 2 : 0);
            chk("mem_we", bus.mem_we, m_we);
            if (m_we) begin
                chk("mem_addr", bus.mem_addr, m_waddr);
                chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
            if (bus.mem_we === 1'b1) shadow[bus.mem_addr] = bus.mem_wdata;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int len, sel, lp;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        start = 1'b0; reset = 1'b1;
        m_active = 1'b0; m_n = 0; m_k = 0; m_we = 1'b0;
        m_t = 0; m_code = 0; cur_t = 0; cur_code = 0;
        for (int i = 0; i < MEM; i++) shadow[i] = '0;

        tick(1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        chk("rst_cpu_run", cpu_run, 0);
        chk("rst_bytes", bytes_loaded, 0);

        // nominal: 04 00 30 F2 0A 00
        build(4, 5); set_nominal_payload();
        chk("model_nom_t", m_t, 5);
        chk("model_nom_code", m_code, 0);
        tick(1'b1, 1'b1, 1'b0);
        run_frame(0);
        idle(2);
        chk("nom_mem0", shadow[0], 8'h30);
        chk("nom_mem1", shadow[1], 8'hF2);
        chk("nom_mem2", shadow[2], 8'h0A);
        chk("nom_mem3", shadow[3], 8'h00);
        chk("nom_bytes", bytes_loaded, 4);
        chk("nom_cpu_run", cpu_run, 1);

        // throttled source, restarted from DONE
        build(4, 5); set_nominal_payload();
        tick(1'b0, 1'b1, 1'b0);
        run_frame(1);
        idle(2);

        // zero length with and without in_last
        build(0, 1);
        tick(1'b0, 1'b1, 1'b0); run_frame(0); idle(2);
        build(0, -1);
        chk("model_zero_nolast", m_code, 3);
        tick(1'b0, 1'b1, 1'b0); run_frame(0); idle(2);

        // capacity boundary: 16 fits, 17 does not
        build(16, 17);
        tick(1'b0, 1'b1, 1'b0); run_frame(2); idle(2);
        chk("full_bytes", bytes_loaded, 16);
        build(17, 18);
        chk("model_toolong", m_code, 1);
        tick(1'b0, 1'b1, 1'b0); run_frame(0); idle(2);
        chk("toolong_code", err_code, 1);
        chk("toolong_ready", bus.in_ready, 0);

        // framing errors
        build(3, 3);
        tick(1'b0, 1'b1, 1'b0); run_frame(0); idle(2);
        chk("short_code", err_code, 2);
        build(2, -1);
        tick(1'b0, 1'b1, 1'b0); run_frame(0); idle(2);
        build(5, 0);
        tick(1'b0, 1'b1, 1'b0); run_frame(0); idle(2);

        // reset after two of four payload bytes
        build(4, 5);
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        chk("midrst_we", bus.mem_we, 0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);

        // start while loading is ignored
        build(6, 7);
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        run_frame(0); idle(2);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            len = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 18))
                                             : int'($urandom_range(17, 600));
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       lp = (len == 0) ? 1 : 1 + len;
            else if (sel == 6) lp = -1;
            else if (sel == 7) lp = 0;
            else if (sel == 8) lp = 1;
            else               lp = (len == 0) ? 1 : int'($urandom_range(2, 1 + len));
            build(len, lp);
            idle(int'($urandom_range(0, 2)));
            tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
            run_frame(2);
            idle(int'($urandom_range(1, 3)));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
